mem_wb_skid: RTL and testbench
==============================

Name: mem_wb_skid

Overview:
- Parametrised MEM->WB pipeline stage with a valid/ready handshake and a one-entry skid buffer.
- Carries the GPR write-back and CSR write-back fields, supports flush, and suppresses writes to x0.
- Emits a registered one-cycle instret pulse for every retired instruction.
- Sits between exe_mem and regfile/csr_file, replacing the unconditional MEM/WB register.

Parameters:
- RADDR_W, 5, GPR address width
- RDATA_W, 32, GPR data width
- CSR_ADDR_W, 12, CSR address width
- CSR_DATA_W, 32, CSR data width
- ZERO_SUPPRESS, 1, when 1, force the GPR write enable low for waddr==0

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  drop all buffered and incoming entries
- in_valid_i  in  1  upstream entry valid
- in_ready_o  out  1  stage can accept an entry; registered
- reg_waddr_i  in  RADDR_W  GPR write address
- reg_we_i  in  1  GPR write enable
- reg_wdata_i  in  RDATA_W  GPR write data
- csr_we_i  in  1  CSR write enable
- csr_waddr_i  in  CSR_ADDR_W  CSR address
- csr_wdata_i  in  CSR_DATA_W  CSR data
- wb_ready_i  in  1  write-back side accepts the head entry
- out_valid_o  out  1  head entry valid
- reg_waddr_o  out  RADDR_W  head GPR address
- reg_we_o  out  1  qualified GPR write enable
- reg_wdata_o  out  RDATA_W  head GPR data
- csr_we_o  out  1  qualified CSR write enable
- csr_waddr_o  out  CSR_ADDR_W  head CSR address
- csr_wdata_o  out  CSR_DATA_W  head CSR data
- instret_incr_o  out  1  one-cycle pulse per retired instruction; registered

Behaviour:
- Storage: head register H and skid register S, each holding a payload plus a valid bit.
- State is encoded by the valid bits:
  - EMPTY: H and S both invalid.
  - ONE: H valid, S invalid.
  - TWO: H and S both valid.
- Handshake:
  - accept = in_valid_i & in_ready_o.
  - retire = out_valid_o & wb_ready_i.
  - in_ready_o = ~S.valid, registered (the next-state value of ~S.valid is flopped).
- Transitions when flush_i=0:
  - EMPTY + accept -> ONE; H <= input.
  - ONE + accept + retire -> ONE; H <= input.
  - ONE + accept + no retire -> TWO; S <= input.
  - ONE + no accept + retire -> EMPTY.
  - ONE + no accept + no retire -> hold.
  - TWO + retire -> ONE; H <= S. Accept is impossible in TWO because in_ready_o=0.
  - TWO + no retire -> hold.
- Latency: accept in cycle N with the stage empty -> out_valid_o=1 in cycle N+1.
- Throughput: one entry per cycle while wb_ready_i stays high.
- Flush: flush_i=1 takes priority over every other event.
  - Next cycle: H.valid=S.valid=0 and in_ready_o=1.
  - An accept in the same cycle is discarded.
  - A retire in the same cycle still counts: the write-back fires and instret pulses.
- Payload registers are not reset and load only when their valid bit is set or updated. Out_valid_o gates every side effect.
- Output qualification (combinational from H and wb_ready_i):
  - out_valid_o = H.valid.
  - reg_we_o = H.valid & H.reg_we & wb_ready_i & ~(ZERO_SUPPRESS & H.reg_waddr==0).
  - csr_we_o = H.valid & H.csr_we & wb_ready_i.
- instret_incr_o:
  - Registered: instret_incr_o <= retire. It is high exactly one cycle after each retire.
  - Retiring a bubble is impossible, because retire requires H.valid.
  - An x0-suppressed instruction still counts as retired.
- Reset (rst_ni low, asynchronous): H.valid=0, S.valid=0, in_ready_o=1, instret_incr_o=0. The output enables are therefore 0.
- Reset asserted mid-operation discards all entries immediately, with no write-back.
- Simultaneous CSR and GPR writes in one entry are both presented in the same cycle.

Decomposition:
- Shared package (extends defines): WRITE_ENABLE/WRITE_DISABLE, ZERO_REG, and width constants for RADDR/RDATA/CSR_ADDR. Add a wb_payload typedef bundling reg_we/reg_waddr/reg_wdata/csr_we/csr_waddr/csr_wdata.
- One natural sub-module, skid_buf, generic over payload width W. It holds H/S storage, the valid bits and the handshake. mem_wb_skid packs and unpacks the payload, and adds output qualification and instret.

Test Plan:
1. Reset then stream: rst_ni low for 2 cycles, then 3 back-to-back entries (x5<=0x11, x6<=0x22, x7<=0x33) with wb_ready_i=1. Expect in_ready_o=1 throughout, reg_we_o pulses in cycles 1-3 after each accept, and instret_incr_o high in cycles 2-4.
2. Backpressure: wb_ready_i=0 while 3 entries are offered. Expect the first two accepted, in_ready_o=0 from the next cycle, and the third held upstream. Then wb_ready_i=1: entries appear in order 0x11, 0x22, 0x33 with none lost or duplicated.
3. x0 suppression: entry reg_we=1, waddr=0, wdata=0xDEAD. Expect reg_we_o=0 and instret_incr_o=1. With ZERO_SUPPRESS=0 expect reg_we_o=1.
4. Flush in TWO with a same-cycle retire: H retires (x5) and flush_i=1. Expect x5 written once, S discarded, and next cycle out_valid_o=0, in_ready_o=1, one instret pulse.
5. CSR write: entry csr_we=1, csr_waddr=0x300, csr_wdata=0x8, plus GPR x1<=0x5. Expect csr_we_o and reg_we_o both high in the same cycle, with the correct address and data.
6. Async reset mid-stall: state TWO, then drop rst_ni between clock edges. Expect out_valid_o=0, reg_we_o=0, csr_we_o=0 immediately. After release, in_ready_o=1.

Source files
------------

// File: rtl/mem_wb_skid_pkg.sv
// Shared write-back constants and the default-width MEM->WB payload bundle.
package mem_wb_skid_pkg;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam int unsigned ZERO_REG      = 0;
    localparam int unsigned RADDR_WIDTH    = 5;
    localparam int unsigned RDATA_WIDTH    = 32;
    localparam int unsigned CSR_ADDR_WIDTH = 12;
    localparam int unsigned CSR_DATA_WIDTH = 32;

    typedef struct packed {
        logic                      reg_we;
        logic [RADDR_WIDTH-1:0]    reg_waddr;
        logic [RDATA_WIDTH-1:0]    reg_wdata;
        logic                      csr_we;
        logic [CSR_ADDR_WIDTH-1:0] csr_waddr;
        logic [CSR_DATA_WIDTH-1:0] csr_wdata;
    } wb_payload_t;

endpackage

// File: rtl/mem_wb_skid_skid_buf.sv
// One-entry skid buffer: head register H plus skid register S with valid/ready handshake.
module skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         h_valid_q, h_valid_d;
    logic         s_valid_q, s_valid_d;
    logic         ready_q;
    logic [W-1:0] h_data_q, s_data_q;
    logic         accept, retire;
    logic         load_h_in, load_h_s, load_s;

    assign accept = in_valid_i & ready_q;
    assign retire = h_valid_q & out_ready_i;

    always_comb begin
        h_valid_d = h_valid_q;
        s_valid_d = s_valid_q;
        load_h_in = 1'b0;
        load_h_s  = 1'b0;
        load_s    = 1'b0;
        if (flush_i) begin
            h_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (s_valid_q) begin
            if (retire) begin
                load_h_s  = 1'b1;
                s_valid_d = 1'b0;
            end
        end else if (h_valid_q) begin
            if (accept && retire) begin
                load_h_in = 1'b1;
            end else if (accept) begin
                load_s    = 1'b1;
                s_valid_d = 1'b1;
            end else if (retire) begin
                h_valid_d = 1'b0;
            end
        end else if (accept) begin
            load_h_in = 1'b1;
            h_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            h_valid_q <= h_valid_d;
            s_valid_q <= s_valid_d;
            ready_q   <= ~s_valid_d;
        end
    end

    // Payload storage is deliberately unreset; the valid bits gate every use.
    always_ff @(posedge clk_i) begin
        if (load_h_in) begin
            h_data_q <= in_data_i;
        end else if (load_h_s) begin
            h_data_q <= s_data_q;
        end
        if (load_s) begin
            s_data_q <= in_data_i;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = h_valid_q;
    assign out_data_o  = h_data_q;

endmodule

// File: rtl/mem_wb_skid.sv
// MEM->WB stage: skid-buffered payload, qualified GPR/CSR write enables, registered instret pulse.
module mem_wb_skid
    import mem_wb_skid_pkg::*;
#(
    parameter int unsigned RADDR_W       = RADDR_WIDTH,
    parameter int unsigned RDATA_W       = RDATA_WIDTH,
    parameter int unsigned CSR_ADDR_W    = CSR_ADDR_WIDTH,
    parameter int unsigned CSR_DATA_W    = CSR_DATA_WIDTH,
    parameter int unsigned ZERO_SUPPRESS = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [RADDR_W-1:0]    reg_waddr_i,
    input  logic                  reg_we_i,
    input  logic [RDATA_W-1:0]    reg_wdata_i,
    input  logic                  csr_we_i,
    input  logic [CSR_ADDR_W-1:0] csr_waddr_i,
    input  logic [CSR_DATA_W-1:0] csr_wdata_i,
    input  logic                  wb_ready_i,
    output logic                  out_valid_o,
    output logic [RADDR_W-1:0]    reg_waddr_o,
    output logic                  reg_we_o,
    output logic [RDATA_W-1:0]    reg_wdata_o,
    output logic                  csr_we_o,
    output logic [CSR_ADDR_W-1:0] csr_waddr_o,
    output logic [CSR_DATA_W-1:0] csr_wdata_o,
    output logic                  instret_incr_o
);

    typedef struct packed {
        logic                  reg_we;
        logic [RADDR_W-1:0]    reg_waddr;
        logic [RDATA_W-1:0]    reg_wdata;
        logic                  csr_we;
        logic [CSR_ADDR_W-1:0] csr_waddr;
        logic [CSR_DATA_W-1:0] csr_wdata;
    } payload_t;

    localparam int unsigned PW = $bits(payload_t);

    payload_t in_pl, head_pl;
    logic     head_valid;
    logic     retire;
    logic     is_x0;
    logic     instret_q;

    assign in_pl = '{reg_we:    reg_we_i,
                     reg_waddr: reg_waddr_i,
                     reg_wdata: reg_wdata_i,
                     csr_we:    csr_we_i,
                     csr_waddr: csr_waddr_i,
                     csr_wdata: csr_wdata_i};

    skid_buf #(
        .W (PW)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_pl),
        .out_valid_o (head_valid),
        .out_ready_i (wb_ready_i),
        .out_data_o  (head_pl)
    );

    assign retire = head_valid & wb_ready_i;
    assign is_x0  = (ZERO_SUPPRESS != 0) && (head_pl.reg_waddr == RADDR_W'(ZERO_REG));

    assign out_valid_o = head_valid;
    assign reg_we_o    = retire & (head_pl.reg_we == WRITE_ENABLE) & ~is_x0;
    assign csr_we_o    = retire & (head_pl.csr_we == WRITE_ENABLE);
    assign reg_waddr_o = head_pl.reg_waddr;
    assign reg_wdata_o = head_pl.reg_wdata;
    assign csr_waddr_o = head_pl.csr_waddr;
    assign csr_wdata_o = head_pl.csr_wdata;

    // Flush does not cancel a same-cycle retire, so instret follows retire alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instret_q <= 1'b0;
        end else begin
            instret_q <= retire;
        end
    end

    assign instret_incr_o = instret_q;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Directed bench for mem_wb_skid: streaming, backpressure, x0 suppression, flush, CSR, async reset.
module tb_mem_wb_skid;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, wb_ready;
    logic [4:0]  waddr;
    logic        we, cwe;
    logic [31:0] wdata, cdata;
    logic [11:0] caddr;

    logic        in_ready, out_valid, reg_we_o, csr_we_o, instret;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o, csr_wdata_o;
    logic [11:0] csr_waddr_o;

    logic        nz_in_ready, nz_out_valid, nz_reg_we, nz_csr_we, nz_instret;
    logic [4:0]  nz_waddr;
    logic [31:0] nz_wdata, nz_cdata;
    logic [11:0] nz_caddr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_wb_skid u_dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .reg_waddr_i(waddr), .reg_we_i(we), .reg_wdata_i(wdata),
        .csr_we_i(cwe), .csr_waddr_i(caddr), .csr_wdata_i(cdata), .wb_ready_i(wb_ready),
        .out_valid_o(out_valid), .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o), .instret_incr_o(instret)
    );

    mem_wb_skid #(.ZERO_SUPPRESS(0)) u_dut_nz (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(nz_in_ready),
        .reg_waddr_i(waddr), .reg_we_i(we), .reg_wdata_i(wdata),
        .csr_we_i(cwe), .csr_waddr_i(caddr), .csr_wdata_i(cdata), .wb_ready_i(wb_ready),
        .out_valid_o(nz_out_valid), .reg_waddr_o(nz_waddr), .reg_we_o(nz_reg_we), .reg_wdata_o(nz_wdata),
        .csr_we_o(nz_csr_we), .csr_waddr_o(nz_caddr), .csr_wdata_o(nz_cdata), .instret_incr_o(nz_instret)
    );

    // Advance to 2 time units after the next rising edge; inputs change here.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic e, input logic [31:0] d,
                         input logic ce, input logic [11:0] ca, input logic [31:0] cd);
        in_valid = v; waddr = a; we = e; wdata = d; cwe = ce; caddr = ca; cdata = cd;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0);
    endtask

    task automatic test_reset_stream();
        rst_n = 1'b0; flush = 1'b0; wb_ready = 1'b1; idle();
        step(); step();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (instret !== 1'b0) begin errors++; $display("FAIL rst_instret got=%b exp=0", instret); end
        checks++; if ({reg_we_o, csr_we_o} !== 2'b00) begin errors++; $display("FAIL rst_we got=%b exp=00", {reg_we_o, csr_we_o}); end
        rst_n = 1'b1;
        step();
        drive(1'b1, 5'd5, 1'b1, 32'h11, 1'b0, 12'h0, 32'h0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL s0_in_ready got=%b exp=1", in_ready); end
        step();
        drive(1'b1, 5'd6, 1'b1, 32'h22, 1'b0, 12'h0, 32'h0);
        #1;
        checks++; if ({out_valid, reg_we_o, reg_waddr_o, reg_wdata_o} !== {1'b1, 1'b1, 5'd5, 32'h11})
            begin errors++; $display("FAIL s1_head got=%b%b %0d %h exp=11 5 11", out_valid, reg_we_o, reg_waddr_o, reg_wdata_o); end
        checks++; if ({in_ready, instret} !== 2'b10) begin errors++; $display("FAIL s1_rdy_inst got=%b exp=10", {in_ready, instret}); end
        step();
        drive(1'b1, 5'd7, 1'b1, 32'h33, 1'b0, 12'h0, 32'h0);
        #1;
        checks++; if ({reg_we_o, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'd6, 32'h22})
            begin errors++; $display("FAIL s2_head got=%b %0d %h exp=1 6 22", reg_we_o, reg_waddr_o, reg_wdata_o); end
        checks++; if ({in_ready, instret} !== 2'b11) begin errors++; $display("FAIL s2_rdy_inst got=%b exp=11", {in_ready, instret}); end
        step();
        idle();
        #1;
        checks++; if ({reg_we_o, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'd7, 32'h33})
            begin errors++; $display("FAIL s3_head got=%b %0d %h exp=1 7 33", reg_we_o, reg_waddr_o, reg_wdata_o); end
        checks++; if ({in_ready, instret} !== 2'b11) begin errors++; $display("FAIL s3_rdy_inst got=%b exp=11", {in_ready, instret}); end
        step();
        #1;
        checks++; if ({out_valid, instret} !== 2'b01) begin errors++; $display("FAIL s4_drain got=%b exp=01", {out_valid, instret}); end
        step();
        #1;
        checks++; if (instret !== 1'b0) begin errors++; $display("FAIL s5_instret got=%b exp=0", instret); end
    endtask

    task automatic test_backpressure();
        wb_ready = 1'b0;
        drive(1'b1, 5'd5, 1'b1, 32'h11, 1'b0, 12'h0, 32'h0);
        step();
        drive(1'b1, 5'd6, 1'b1, 32'h22, 1'b0, 12'h0, 32'h0);
        #1;
        checks++; if ({in_ready, out_valid, reg_we_o, reg_wdata_o} !== {1'b1, 1'b1, 1'b0, 32'h11})
            begin errors++; $display("FAIL bp1 got=%b%b%b %h exp=110 11", in_ready, out_valid, reg_we_o, reg_wdata_o); end
        step();
        drive(1'b1, 5'd7, 1'b1, 32'h33, 1'b0, 12'h0, 32'h0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp2_in_ready got=%b exp=0", in_ready); end
        step();
        #1;
        checks++; if ({in_ready, reg_wdata_o} !== {1'b0, 32'h11}) begin errors++; $display("FAIL bp3_hold got=%b %h exp=0 11", in_ready, reg_wdata_o); end
        wb_ready = 1'b1;
        #1;
        checks++; if ({reg_we_o, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'd5, 32'h11})
            begin errors++; $display("FAIL bp3_out got=%b %0d %h exp=1 5 11", reg_we_o, reg_waddr_o, reg_wdata_o); end
        step();
        #1;
        checks++; if ({in_ready, reg_we_o, reg_waddr_o, reg_wdata_o} !== {1'b1, 1'b1, 5'd6, 32'h22})
            begin errors++; $display("FAIL bp4_out got=%b%b %0d %h exp=11 6 22", in_ready, reg_we_o, reg_waddr_o, reg_wdata_o); end
        step();
        idle();
        #1;
        checks++; if ({reg_we_o, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'd7, 32'h33})
            begin errors++; $display("FAIL bp5_out got=%b %0d %h exp=1 7 33", reg_we_o, reg_waddr_o, reg_wdata_o); end
        step();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp6_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_x0_suppress();
        wb_ready = 1'b1;
        drive(1'b1, 5'd0, 1'b1, 32'hDEAD, 1'b0, 12'h0, 32'h0);
        step();
        idle();
        #1;
        checks++; if ({out_valid, reg_we_o} !== 2'b10) begin errors++; $display("FAIL x0_sup got=%b exp=10", {out_valid, reg_we_o}); end
        checks++; if ({nz_out_valid, nz_reg_we, nz_waddr, nz_wdata} !== {1'b1, 1'b1, 5'd0, 32'hDEAD})
            begin errors++; $display("FAIL x0_nosup got=%b%b %0d %h exp=11 0 dead", nz_out_valid, nz_reg_we, nz_waddr, nz_wdata); end
        step();
        #1;
        checks++; if ({instret, nz_instret} !== 2'b11) begin errors++; $display("FAIL x0_instret got=%b exp=11", {instret, nz_instret}); end
    endtask

    task automatic test_flush();
        wb_ready = 1'b0;
        drive(1'b1, 5'd5, 1'b1, 32'h55, 1'b0, 12'h0, 32'h0);
        step();
        drive(1'b1, 5'd6, 1'b1, 32'h66, 1'b0, 12'h0, 32'h0);
        step();
        idle();
        wb_ready = 1'b1; flush = 1'b1;
        #1;
        checks++; if ({in_ready, reg_we_o, reg_waddr_o, reg_wdata_o} !== {1'b0, 1'b1, 5'd5, 32'h55})
            begin errors++; $display("FAIL fl_retire got=%b%b %0d %h exp=01 5 55", in_ready, reg_we_o, reg_waddr_o, reg_wdata_o); end
        step();
        flush = 1'b0;
        #1;
        checks++; if ({out_valid, reg_we_o, in_ready, instret} !== 4'b0011)
            begin errors++; $display("FAIL fl_after got=%b exp=0011", {out_valid, reg_we_o, in_ready, instret}); end
        step();
        #1;
        checks++; if ({out_valid, instret} !== 2'b00) begin errors++; $display("FAIL fl_s_gone got=%b exp=00", {out_valid, instret}); end
        // Accept offered during flush must be dropped.
        drive(1'b1, 5'd9, 1'b1, 32'h99, 1'b0, 12'h0, 32'h0);
        flush = 1'b1;
        step();
        idle();
        flush = 1'b0;
        #1;
        checks++; if ({out_valid, reg_we_o, in_ready} !== 3'b001) begin errors++; $display("FAIL fl_drop got=%b exp=001", {out_valid, reg_we_o, in_ready}); end
    endtask

    task automatic test_csr();
        wb_ready = 1'b1;
        drive(1'b1, 5'd1, 1'b1, 32'h5, 1'b1, 12'h300, 32'h8);
        step();
        idle();
        #1;
        checks++; if ({csr_we_o, reg_we_o} !== 2'b11) begin errors++; $display("FAIL csr_both got=%b exp=11", {csr_we_o, reg_we_o}); end
        checks++; if ({csr_waddr_o, csr_wdata_o, reg_waddr_o, reg_wdata_o} !== {12'h300, 32'h8, 5'd1, 32'h5})
            begin errors++; $display("FAIL csr_fields got=%h %h %0d %h exp=300 8 1 5", csr_waddr_o, csr_wdata_o, reg_waddr_o, reg_wdata_o); end
        step();
        #1;
        checks++; if ({out_valid, csr_we_o} !== 2'b00) begin errors++; $display("FAIL csr_done got=%b exp=00", {out_valid, csr_we_o}); end
    endtask

    task automatic test_async_reset();
        wb_ready = 1'b0;
        drive(1'b1, 5'd3, 1'b1, 32'hA, 1'b1, 12'h301, 32'hB);
        step();
        drive(1'b1, 5'd4, 1'b1, 32'hC, 1'b1, 12'h302, 32'hD);
        step();
        idle();
        wb_ready = 1'b1;
        #1;
        checks++; if ({in_ready, out_valid, reg_we_o, csr_we_o} !== 4'b0111)
            begin errors++; $display("FAIL ar_pre got=%b exp=0111", {in_ready, out_valid, reg_we_o, csr_we_o}); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, reg_we_o, csr_we_o, instret} !== 4'b0000)
            begin errors++; $display("FAIL ar_now got=%b exp=0000", {out_valid, reg_we_o, csr_we_o, instret}); end
        step();
        rst_n = 1'b1;
        #1;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL ar_release got=%b exp=10", {in_ready, out_valid}); end
        step();
        #1;
        checks++; if ({out_valid, instret} !== 2'b00) begin errors++; $display("FAIL ar_no_wb got=%b exp=00", {out_valid, instret}); end
    endtask

    initial begin
        test_reset_stream();
        test_backpressure();
        test_x0_suppress();
        test_flush();
        test_csr();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
